// File: rtl/ascensor_pkg.sv
// ascensor_pkg: direction codes, floor count and controller state encoding shared by the elevator blocks
package ascensor_pkg;
  localparam int NUM_PISOS = 4;
  localparam logic [1:0] DIR_REPOSO = 2'b00;
  localparam logic [1:0] DIR_SUBE = 2'b01;
  localparam logic [1:0] DIR_BAJA = 2'b10;
  typedef enum logic [1:0] {REPOSO, SUBIENDO, BAJANDO, PUERTAS} estado_t;
endpackage

// File: rtl/temporizador_ascensor.sv
// temporizador_ascensor: clearable up-counter that saturates at all-ones and flags when it equals a limit
module temporizador_ascensor #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limite,
  output logic         o_expira
);
  logic [W-1:0] r_cuenta;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cuenta <= '0;
    else if (i_clr) r_cuenta <= '0;
    else if (i_en && r_cuenta != '1) r_cuenta <= r_cuenta + 1'b1;
  assign o_expira = r_cuenta == i_limite;
endmodule

// File: rtl/controlador_ascensor.sv
// controlador_ascensor: single-car 4-floor elevator controller; latches calls, travels one floor per
// T_VIAJE cycles and holds the doors open T_PUERTA cycles at each requested floor
module controlador_ascensor
  import ascensor_pkg::*;
#(
  parameter int T_VIAJE = 50000000,
  parameter int T_PUERTA = 100000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PISOS-1:0] llamada,
  output logic [1:0]           piso,
  output logic [1:0]           direccion,
  output logic                 puertas_abiertas,
  output logic [NUM_PISOS-1:0] pendientes
);
  localparam int T_MAX = T_VIAJE > T_PUERTA ? T_VIAJE : T_PUERTA;
  localparam int TW = $clog2(T_MAX);
  estado_t r_estado, w_estado_nxt;
  logic [1:0] r_piso, w_piso_nxt, w_vecino, r_dir, w_dir_nxt;
  logic [NUM_PISOS-1:0] r_pend, w_limpiar, w_ignorar;
  logic [NUM_PISOS-1:0] w_arriba_p, w_abajo_p, w_arriba_v, w_abajo_v;
  logic r_ultima_sube, w_ultima_sube_nxt, r_puertas, w_puertas_nxt;
  logic w_expira, w_clr, w_reabrir;
  // Masks for the current floor and for the floor the car is about to reach
  assign w_vecino = r_estado == BAJANDO ? r_piso - 2'd1 : r_piso + 2'd1;
  assign w_arriba_p = r_pend & (4'b1110 << r_piso);
  assign w_abajo_p = r_pend & ((4'b0001 << r_piso) - 4'd1);
  assign w_arriba_v = r_pend & (4'b1110 << w_vecino);
  assign w_abajo_v = r_pend & ((4'b0001 << w_vecino) - 4'd1);
  assign w_reabrir = r_estado == PUERTAS && llamada[r_piso];
  assign w_ignorar = {NUM_PISOS{r_estado == PUERTAS}} & (4'b0001 << r_piso);
  assign w_clr = w_estado_nxt != r_estado || w_piso_nxt != r_piso || w_reabrir;
  temporizador_ascensor #(.W(TW)) u_tmr (
    .clk(clk),
    .rst(rst),
    .i_clr(w_clr),
    .i_en(r_estado != REPOSO),
    .i_limite(r_estado == PUERTAS ? TW'(T_PUERTA - 1) : TW'(T_VIAJE - 1)),
    .o_expira(w_expira)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_estado <= REPOSO;
      r_piso <= '0;
      r_pend <= '0;
      r_ultima_sube <= 1'b1;
      r_dir <= DIR_REPOSO;
      r_puertas <= 1'b0;
    end else begin
      r_estado <= w_estado_nxt;
      r_piso <= w_piso_nxt;
      r_pend <= (r_pend | (llamada & ~w_ignorar)) & ~w_limpiar;
      r_ultima_sube <= w_ultima_sube_nxt;
      r_dir <= w_dir_nxt;
      r_puertas <= w_puertas_nxt;
    end
  always_comb begin
    w_estado_nxt = r_estado;
    w_piso_nxt = r_piso;
    w_ultima_sube_nxt = r_ultima_sube;
    w_limpiar = '0;
    case (r_estado)
      REPOSO:
        if (r_pend[r_piso]) begin
          w_estado_nxt = PUERTAS;
          w_limpiar[r_piso] = 1'b1;
        end else if (|w_arriba_p && (r_ultima_sube || ~|w_abajo_p)) begin
          w_estado_nxt = SUBIENDO;
          w_ultima_sube_nxt = 1'b1;
        end else if (|w_abajo_p) begin
          w_estado_nxt = BAJANDO;
          w_ultima_sube_nxt = 1'b0;
        end
      SUBIENDO, BAJANDO:
        if (r_estado == SUBIENDO ? r_piso == 2'd3 : r_piso == 2'd0) w_estado_nxt = REPOSO;
        else if (w_expira) begin
          w_piso_nxt = w_vecino;
          if (r_pend[w_vecino]) begin
            w_estado_nxt = PUERTAS;
            w_limpiar[w_vecino] = 1'b1;
          end else if (!(r_estado == SUBIENDO ? |w_arriba_v : |w_abajo_v)) w_estado_nxt = REPOSO;
        end
      PUERTAS: if (w_expira && !w_reabrir) w_estado_nxt = REPOSO;
      default: w_estado_nxt = REPOSO;
    endcase
  end
  always_comb begin
    w_dir_nxt = w_estado_nxt == SUBIENDO ? DIR_SUBE : w_estado_nxt == BAJANDO ? DIR_BAJA : DIR_REPOSO;
    w_puertas_nxt = w_estado_nxt == PUERTAS;
  end
  assign piso = r_piso;
  assign direccion = r_dir;
  assign puertas_abiertas = r_puertas;
  assign pendientes = r_pend;
endmodule

// File: tb/tb_controlador_ascensor.sv
// tb_controlador_ascensor: directed table plus hand sequences for the elevator controller (T_VIAJE=4, T_PUERTA=6)
module tb_controlador_ascensor;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] llamada = '0;
  logic [1:0] piso, direccion;
  logic puertas_abiertas;
  logic [3:0] pendientes;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic [3:0] ll;
    int n;
    logic [1:0] p;
    logic [1:0] d;
    logic pu;
    logic [3:0] pe;
  } vec_t;
  vec_t tabla[11];
  controlador_ascensor #(.T_VIAJE(4), .T_PUERTA(6)) dut (
    .clk(clk),
    .rst(rst),
    .llamada(llamada),
    .piso(piso),
    .direccion(direccion),
    .puertas_abiertas(puertas_abiertas),
    .pendientes(pendientes)
  );
  always #5 clk = ~clk;
  task automatic paso(input logic [3:0] ll, input int n);
    for (int i = 0; i < n; i++) begin
      llamada = ll;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string nombre, input logic [1:0] p, input logic [1:0] d, input logic pu, input logic [3:0] pe);
    n_cmp++;
    if ({piso, direccion, puertas_abiertas, pendientes} !== {p, d, pu, pe}) begin
      n_err++;
      $display("FAIL %s: piso/dir/puertas/pend got %0d/%b/%b/%b expected %0d/%b/%b/%b",
               nombre, piso, direccion, puertas_abiertas, pendientes, p, d, pu, pe);
    end
  endtask
  task automatic esperar(input logic abiertas, input string nombre);
    for (int i = 0; i < 40 && puertas_abiertas !== abiertas; i++) paso(4'b0000, 1);
    n_cmp++;
    if (puertas_abiertas !== abiertas) begin
      n_err++;
      $display("FAIL %s: puertas got %b expected %b within 40 cycles", nombre, puertas_abiertas, abiertas);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tabla[0]  = '{4'b0001, 1, 2'd0, 2'b00, 1'b0, 4'b0001};
    tabla[1]  = '{4'b0000, 1, 2'd0, 2'b00, 1'b1, 4'b0000};
    tabla[2]  = '{4'b0000, 5, 2'd0, 2'b00, 1'b1, 4'b0000};
    tabla[3]  = '{4'b0000, 1, 2'd0, 2'b00, 1'b0, 4'b0000};
    tabla[4]  = '{4'b0100, 1, 2'd0, 2'b00, 1'b0, 4'b0100};
    tabla[5]  = '{4'b0000, 1, 2'd0, 2'b01, 1'b0, 4'b0100};
    tabla[6]  = '{4'b0000, 3, 2'd0, 2'b01, 1'b0, 4'b0100};
    tabla[7]  = '{4'b0000, 1, 2'd1, 2'b01, 1'b0, 4'b0100};
    tabla[8]  = '{4'b0000, 4, 2'd2, 2'b00, 1'b1, 4'b0000};
    tabla[9]  = '{4'b0000, 5, 2'd2, 2'b00, 1'b1, 4'b0000};
    tabla[10] = '{4'b0000, 1, 2'd2, 2'b00, 1'b0, 4'b0000};
    #12;
    chk("reset_state", 2'd0, 2'b00, 1'b0, 4'b0000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      paso(tabla[i].ll, tabla[i].n);
      chk($sformatf("vec%0d", i), tabla[i].p, tabla[i].d, tabla[i].pu, tabla[i].pe);
    end
    // Asynchronous reset while descending from 2 toward 0
    paso(4'b0001, 1);
    paso(4'b0000, 1);
    chk("pre_reset_moving", 2'd2, 2'b10, 1'b0, 4'b0001);
    #3 rst = 1'b1;
    #1 chk("async_reset", 2'd0, 2'b00, 1'b0, 4'b0000);
    rst = 1'b0;
    paso(4'b0000, 2);
    chk("idle_after_reset", 2'd0, 2'b00, 1'b0, 4'b0000);
    // Direction preference after an up trip
    paso(4'b0010, 1);
    esperar(1'b1, "open_at_1");
    chk("at_floor_1", 2'd1, 2'b00, 1'b1, 4'b0000);
    esperar(1'b0, "close_at_1");
    paso(4'b1001, 1);
    chk("latch_1001", 2'd1, 2'b00, 1'b0, 4'b1001);
    paso(4'b0000, 1);
    chk("prefer_up", 2'd1, 2'b01, 1'b0, 4'b1001);
    esperar(1'b1, "open_at_3");
    chk("stop_3_first", 2'd3, 2'b00, 1'b1, 4'b0001);
    esperar(1'b0, "close_at_3");
    paso(4'b0000, 1);
    chk("then_down", 2'd3, 2'b10, 1'b0, 4'b0001);
    esperar(1'b1, "open_at_0");
    chk("stop_0", 2'd0, 2'b00, 1'b1, 4'b0000);
    esperar(1'b0, "close_at_0");
    // Intermediate stop while descending 3 -> 0
    paso(4'b1000, 1);
    esperar(1'b1, "open_at_3b");
    chk("at_3_again", 2'd3, 2'b00, 1'b1, 4'b0000);
    esperar(1'b0, "close_at_3b");
    paso(4'b0001, 1);
    paso(4'b0000, 1);
    chk("descend_start", 2'd3, 2'b10, 1'b0, 4'b0001);
    paso(4'b0010, 1);
    chk("mid_call_latched", 2'd3, 2'b10, 1'b0, 4'b0011);
    esperar(1'b1, "open_at_1b");
    chk("intermediate_stop_1", 2'd1, 2'b00, 1'b1, 4'b0001);
    esperar(1'b0, "close_at_1b");
    esperar(1'b1, "open_at_0b");
    chk("continue_to_0", 2'd0, 2'b00, 1'b1, 4'b0000);
    // Door re-open: own-floor call restarts timer, other floor latches
    paso(4'b0101, 8);
    chk("reopen_hold", 2'd0, 2'b00, 1'b1, 4'b0100);
    paso(4'b0000, 5);
    chk("reopen_still_open", 2'd0, 2'b00, 1'b1, 4'b0100);
    paso(4'b0000, 1);
    chk("reopen_closed", 2'd0, 2'b00, 1'b0, 4'b0100);
    paso(4'b0000, 1);
    chk("leave_for_2", 2'd0, 2'b01, 1'b0, 4'b0100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
